// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if
//   Bundles the fetch-side, instruction-memory and decoder-side signals of
//   the instruction fetch queue.
//   master : upstream environment (PC, imem, flush, decoder ready)
//   slave  : the ifetch_queue itself
//   Signals:
//     pc_in, fetch_req, fetch_stall  - program counter side
//     imem_addr, imem_rdata          - synchronous instruction memory
//     flush                          - branch-taken discard
//     ir_valid, ir_ready, ir_data,
//     ir_pc, count                   - decoder side / occupancy
interface ifetch_queue_if #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] pc_in;
    logic          fetch_req;
    logic          fetch_stall;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          flush;
    logic          ir_valid;
    logic          ir_ready;
    logic [DW-1:0] ir_data;
    logic [AW-1:0] ir_pc;
    logic [CW-1:0] count;

    modport master (
        output pc_in, fetch_req, imem_rdata, flush, ir_ready,
        input  fetch_stall, imem_addr, ir_valid, ir_data, ir_pc, count
    );

    modport slave (
        input  pc_in, fetch_req, imem_rdata, flush, ir_ready,
        output fetch_stall, imem_addr, ir_valid, ir_data, ir_pc, count
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue
//   Instruction fetch stage: forwards pc_in to the synchronous instruction
//   memory, captures the returned byte with its PC one cycle later into a
//   DEPTH-entry FIFO, and presents the head entry to the decoder over a
//   valid/ready handshake. flush discards queued and in-flight fetches.
//   Ports:
//     clk - rising-edge clock
//     rst - synchronous active-high reset (also clears storage)
//     q   - ifetch_queue_if slave modport (PC, imem, flush, decoder side)
module ifetch_queue #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    ifetch_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;
    logic          inflight;
    logic [AW-1:0] inflight_pc;
    logic [DW-1:0] mem_data [DEPTH];
    logic [AW-1:0] mem_pc   [DEPTH];

    logic          stall;
    logic          valid;
    logic          launch;
    logic          push;
    logic          pop;

    // An in-flight fetch reserves a slot, so stall from occupancy+inflight
    // guarantees the returning byte always has room.
    always_comb begin
        stall  = q.flush |
                 (({1'b0, cnt} + (CW+1)'(inflight)) >= (CW+1)'(DEPTH));
        valid  = (cnt != '0) & ~q.flush;
        launch = q.fetch_req & ~stall;
        push   = inflight;
        pop    = valid & q.ir_ready;
    end

    assign q.fetch_stall = stall;
    assign q.imem_addr   = q.pc_in;
    assign q.ir_valid    = valid;
    assign q.ir_data     = mem_data[head];
    assign q.ir_pc       = mem_pc[head];
    assign q.count       = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            cnt         <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else if (q.flush) begin
            // Response returning next cycle is dropped by clearing inflight.
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
        end else begin
            if (push) begin
                mem_data[tail] <= q.imem_rdata;
                mem_pc[tail]   <= inflight_pc;
                tail           <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            inflight <= launch;
            if (launch) begin
                inflight_pc <= q.pc_in;
            end
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    typedef logic [AW+DW-1:0] ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifetch_queue_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

    ifetch_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus.slave)
    );

    // Synchronous instruction memory: contents are ~addr.
    always @(posedge clk) bus.imem_rdata <= ~bus.imem_addr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of {pc, data} plus one pending fetch.
    ent_t          m_q [$];
    bit            m_inflight;
    logic [AW-1:0] m_ipc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic req,
                        input logic [AW-1:0] pc, input logic rdy,
                        output logic launched);
        int  exp_cnt;
        bit  exp_stall;
        bit  exp_valid;
        @(negedge clk);
        rst           = r;
        bus.flush     = f;
        bus.fetch_req = req;
        bus.pc_in     = pc;
        bus.ir_ready  = rdy;
        #1;
        exp_cnt   = m_q.size();
        exp_stall = f || ((m_q.size() + int'(m_inflight)) >= DEPTH);
        exp_valid = (m_q.size() != 0) && !f;
        check("count", 32'(bus.count), exp_cnt);
        check("fetch_stall", 32'(bus.fetch_stall), 32'(exp_stall));
        check("ir_valid", 32'(bus.ir_valid), 32'(exp_valid));
        check("imem_addr", 32'(bus.imem_addr), 32'(pc));
        if (exp_valid) begin
            check("ir_pc", 32'(bus.ir_pc), 32'(m_q[0][AW+DW-1:DW]));
            check("ir_data", 32'(bus.ir_data), 32'(m_q[0][DW-1:0]));
        end
        launched = req && !exp_stall && !r;
        @(posedge clk);
        if (r || f) begin
            m_q.delete();
            m_inflight = 1'b0;
        end else begin
            if (exp_valid && rdy) void'(m_q.pop_front());
            if (m_inflight) m_q.push_back({m_ipc, ~m_ipc});
            m_inflight = launched;
            if (launched) m_ipc = pc;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        rst = 1'b0; bus.flush = 1'b0; bus.fetch_req = 1'b0; bus.ir_ready = 1'b0;
        #1;
        check({tag, "_count"}, 32'(bus.count), 0);
        check({tag, "_valid"}, 32'(bus.ir_valid), 0);
        check({tag, "_data"},  32'(bus.ir_data), 0);
        check({tag, "_pc"},    32'(bus.ir_pc), 0);
        check({tag, "_stall"}, 32'(bus.fetch_stall), 0);
    endtask

    task automatic do_reset();
        logic l;
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, l);
    endtask

    initial begin
        logic          l;
        logic [AW-1:0] pc;
        int            first_valid;

        rst = 1'b1; bus.flush = 1'b0; bus.fetch_req = 1'b0;
        bus.pc_in = '0; bus.ir_ready = 1'b0;
        repeat (2) @(posedge clk);
        m_q.delete(); m_inflight = 1'b0; m_ipc = '0;
        check_reset_outputs("reset");

        // Streaming: one instruction per cycle, first valid two cycles after launch.
        pc = 8'h80;
        first_valid = -1;
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b0, 1'b1, pc, 1'b1, l);
            if (bus.ir_valid && first_valid < 0) first_valid = i;
            if (l) pc++;
        end
        check("first_valid_cycle", 32'(first_valid), 2);

        // Back-pressure: fill to DEPTH, then drain in order.
        do_reset();
        pc = 8'h80;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, pc, 1'b0, l);
            if (l) pc++;
        end
        check("full_count", 32'(bus.count), DEPTH);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, pc, 1'b1, l);

        // Flush with three queued plus one in flight; wrong-path PC in flush cycle.
        do_reset();
        pc = 8'h80;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, pc, 1'b0, l);
            if (l) pc++;
        end
        step(1'b0, 1'b1, 1'b1, 8'h55, 1'b0, l);
        check("flush_launch", 32'(l), 0);
        step(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, l);
        check("post_flush_count", 32'(bus.count), 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h55, 1'b1, l);
            if (bus.ir_valid) check("no_wrong_path_pc", 32'(bus.ir_pc == 8'h55), 0);
        end

        // Simultaneous push/pop at count 2 across pointer wrap.
        do_reset();
        pc = 8'h10;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, pc, 1'b0, l);
            if (l) pc++;
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b1, pc, 1'b1, l);
            if (l) pc++;
        end
        check("steady_count", 32'(bus.count), 2);

        // Reset mid-stream with full queue.
        pc = 8'h20;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b1, pc, 1'b0, l);
            if (l) pc++;
        end
        step(1'b1, 1'b0, 1'b1, pc, 1'b0, l);
        check_reset_outputs("midrst");
        pc = 8'h40;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, pc, 1'b1, l);
            if (l) pc++;
        end

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic r, f, req, rdy;
            r   = ($urandom_range(0, 99) < 2);
            f   = ($urandom_range(0, 99) < 8);
            req = ($urandom_range(0, 99) < 75);
            rdy = ($urandom_range(0, 99) < 60);
            step(r, f, req, AW'($urandom), rdy, l);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch stage sitting directly downstream of the program counter. It takes the current PC, issues it as an address to the synchronous instruction memory, and captures the returned instruction byte together with its PC into a small FIFO. The FIFO feeds the decoder/control unit over a valid/ready handshake. A branch flush discards everything fetched down the wrong path, and a stall output throttles the PC.

## Interface
Parameters:
- AW, 8, address/PC width
- DW, 8, instruction width
- DEPTH, 4, FIFO entries; must be a power of two and at least 2

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- pc_in  in  AW  current PC from the program counter
- fetch_req  in  1  pc_in is a valid fetch address this cycle
- fetch_stall  out  1  queue cannot accept a fetch this cycle; upstream must hold the PC
- imem_addr  out  AW  instruction memory read address, combinational copy of pc_in
- imem_rdata  in  DW  instruction memory read data, valid one cycle after the address
- flush  in  1  branch taken: discard queued and in-flight fetches
- ir_valid  out  1  head entry is valid
- ir_ready  in  1  decoder accepts the head entry
- ir_data  out  DW  head instruction
- ir_pc  out  AW  PC of the head instruction
- count  out  clog2(DEPTH)+1  number of valid entries

## Operation
- A fetch launches when fetch_req=1, fetch_stall=0 and flush=0.
  - On the launching edge, the inflight flag is set and pc_in is latched as inflight_pc.
- In the cycle after a launch, imem_rdata and inflight_pc are written into the FIFO at the tail. The tail pointer is incremented and the inflight flag is cleared, unless another launch re-sets it.
- A pop occurs when ir_valid=1 and ir_ready=1; the head pointer increments.
- A push and a pop may occur on the same edge. count is then unchanged.
- Pointers wrap modulo DEPTH.
- fetch_stall = flush | ((count + inflight) >= DEPTH).
  - It is computed from registered state and flush only, never from ir_ready.
  - Because an in-flight fetch reserves a slot, overflow is impossible by construction.
- ir_valid = (count != 0) & ~flush. No transfer happens in a flush cycle.
- ir_data and ir_pc always present the head slot contents. Their values are meaningless while ir_valid=0.
- Flush, on the edge where flush=1:
  - count, head and tail are set to 0 and inflight is cleared.
  - The response returning the next cycle is not written.
  - fetch_req in the flush cycle is ignored, because pc_in still holds the wrong-path address.
- Priority per edge: rst > flush > push/pop.
- There is no state machine beyond the inflight flag and the FIFO pointers.

## Timing
- Reset values: count=0, inflight=0, head=tail=0, all storage=0.
  - This gives ir_valid=0, ir_data=0, ir_pc=0 and fetch_stall=0 (with flush=0).
- Reset mid-operation discards all entries and in-flight data. It behaves as flush plus storage clear.
- Latency: fetch launched in cycle N appears at ir_valid/ir_data/ir_pc in cycle N+2.
- Throughput: one instruction per cycle sustained while the decoder pops every cycle. Requires DEPTH ≥ 2.
- After a flush in cycle F:
  - ir_valid=0 in cycle F+1.
  - The first post-branch fetch can launch in F+1 and becomes visible in F+3.
- imem_addr has zero latency from pc_in and is driven even when no fetch launches.
- Full boundary (count=DEPTH):
  - fetch_stall=1.
  - A pop in that cycle does not lower fetch_stall until the next cycle.

## Test plan
- Reset, then fetch_req=1 every cycle with pc_in=0x80,0x81,…, memory returning ~addr, and ir_ready=1 -> ir_valid first high 2 cycles after the first launch. Output pairs are (0x80,0x7F), (0x81,0x7E), … one per cycle with no gaps.
- ir_ready=0 with continuous fetch_req -> count reaches 4 and fetch_stall=1 from count+inflight=4. No entry is lost or overwritten. Releasing ir_ready drains 0x80..0x83 in order.
- Flush with 3 entries queued plus one in flight -> next cycle count=0, ir_valid=0, and the returning in-flight byte is not enqueued. Then fetch 0xAA -> ir_pc=0xAA, 2 cycles after its launch.
- Simultaneous push and pop at count=2 -> count stays 2 and head data is correct across pointer wrap after more than 8 transfers.
- rst asserted mid-stream with queue full -> all outputs return to their reset values on the next cycle, and the stream restarts cleanly.
- fetch_req=1 during the flush cycle -> no launch, and pc_in of that cycle never appears on ir_pc.
